// File: rtl/paddle_cmd_issuer.sv
// Purpose: debounce the two paddle buttons and issue clamped coordY updates to the paddle renderer.
// Latency: about 2 + DEBOUNCE_CYCLES cycles from a stable press to the clk_en strobe; repeats every REPEAT_CYCLES while held.
// Backpressure: one update in flight; waits for y_Atual == coordY (or TIMEOUT_CYCLES) before accepting the next request.
module paddle_cmd_issuer #(
  parameter int Y_INIT          = 195,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 389,
  parameter int STEP            = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 1500000,
  parameter int TIMEOUT_CYCLES  = 2097152
) (
  input  logic       clk_in,
  input  logic       i_rst,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       enable,
  input  logic       clr_err,
  input  logic [8:0] y_Atual,
  output logic [8:0] coordY,
  output logic       refreshBar,
  output logic       clk_en,
  output logic       busy,
  output logic       timeout_err
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LOAD  = RP_W'(REPEAT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]      STEP10   = 10'(STEP);
  localparam logic [9:0]      MIN_STEP = 10'(Y_MIN + STEP);
  localparam logic [9:0]      MAX10    = 10'(Y_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, HOLD} state_t;

  state_t          state;
  logic [1:0]      sync1, sync2;   // bit 0 = up, bit 1 = down; 1 = released
  logic [1:0]      db_n;
  logic [DB_W-1:0] db_cnt [2];
  logic [8:0]      pos;
  logic            dir_down;
  logic [TO_W-1:0] tcnt;
  logic [RP_W-1:0] rcnt;

  logic            up_req, down_req, hold_req;
  logic [9:0]      pos_ext;
  logic [8:0]      up_tgt, down_tgt, hold_tgt;

  // Two-flop synchronizer for the raw buttons; idle level is released.
  always_ff @(posedge clk_in or negedge i_rst) begin
    if (!i_rst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {btn_down_n, btn_up_n};
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk_in or negedge i_rst) begin
    if (!i_rst) begin
      db_n <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db_n[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_n[i]   <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign up_req   = !db_n[0] &&  db_n[1];
  assign down_req =  db_n[0] && !db_n[1];
  assign pos_ext  = {1'b0, pos};
  assign up_tgt   = (pos_ext < MIN_STEP) ? 9'(Y_MIN) : 9'(pos_ext - STEP10);
  assign down_tgt = (pos_ext + STEP10 > MAX10) ? 9'(Y_MAX) : 9'(pos_ext + STEP10);
  assign hold_req = dir_down ? down_req : up_req;
  assign hold_tgt = dir_down ? down_tgt : up_tgt;

  // Update FSM: issue one strobe, wait for the renderer to catch up, then hold-to-repeat.
  always_ff @(posedge clk_in or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      pos         <= 9'(Y_INIT);
      coordY      <= 9'(Y_INIT);
      refreshBar  <= 1'b0;
      clk_en      <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      dir_down    <= 1'b0;
      tcnt        <= '0;
      rcnt        <= '0;
    end else begin
      // A timeout later in this block overrides the clear.
      if (clr_err) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && up_req && (up_tgt != pos)) begin
            coordY     <= up_tgt;
            dir_down   <= 1'b0;
            clk_en     <= 1'b1;
            refreshBar <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end else if (enable && down_req && (down_tgt != pos)) begin
            coordY     <= down_tgt;
            dir_down   <= 1'b1;
            clk_en     <= 1'b1;
            refreshBar <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          clk_en     <= 1'b0;
          refreshBar <= 1'b0;
          tcnt       <= '0;
          state      <= WAIT_ACK;
        end
        WAIT_ACK: begin
          tcnt <= tcnt + 1'b1;
          if (y_Atual == coordY) begin
            pos   <= coordY;
            rcnt  <= RP_LOAD;
            busy  <= 1'b0;
            state <= HOLD;
          end else if (tcnt == TO_LAST) begin
            timeout_err <= 1'b1;
            pos         <= y_Atual;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        HOLD: begin
          if (!enable || !hold_req) begin
            state <= IDLE;
          end else if (rcnt == '0) begin
            if (hold_tgt != pos) begin
              coordY     <= hold_tgt;
              clk_en     <= 1'b1;
              refreshBar <= 1'b1;
              busy       <= 1'b1;
              state      <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end else begin
            rcnt <= rcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_cmd_issuer.sv
// Purpose: directed self-checking bench for paddle_cmd_issuer with short debounce/repeat/timeout values.
// Latency: stimulus driven and outputs sampled on the falling clock edge.
// Backpressure: the renderer acknowledge is modelled by writing y_Atual from the stimulus sequence.
module tb_paddle_cmd_issuer;

  logic       clk_in = 1'b0;
  logic       i_rst;
  logic       btn_up_n, btn_down_n, enable, clr_err;
  logic [8:0] y_Atual;
  logic [8:0] coordY;
  logic       refreshBar, clk_en, busy, timeout_err;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int base;
  bit ok;

  paddle_cmd_issuer #(
    .Y_INIT(195), .Y_MIN(0), .Y_MAX(389), .STEP(5),
    .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_in(clk_in), .i_rst(i_rst), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
    .enable(enable), .clr_err(clr_err), .y_Atual(y_Atual), .coordY(coordY),
    .refreshBar(refreshBar), .clk_en(clk_en), .busy(busy), .timeout_err(timeout_err)
  );

  // Free-running 10-unit clock.
  always #5 clk_in = ~clk_in;

  // Count write strobes using the pre-edge value of clk_en.
  always @(posedge clk_in) begin
    if (clk_en === 1'b1) pulses <= pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Wait on the falling edge for a strobe, giving up after max cycles.
  task automatic wait_pulse(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_in);
      if (clk_en === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    i_rst = 1'b0; btn_up_n = 1'b1; btn_down_n = 1'b1;
    enable = 1'b1; clr_err = 1'b0; y_Atual = 9'd195;
    cycles(3);
    check("reset_coordY", coordY, 195);
    check("reset_busy", busy, 0);
    i_rst = 1'b1;

    // Idle with both buttons released.
    cycles(20);
    check("idle_coordY", coordY, 195);
    check("idle_pulses", pulses, 0);
    check("idle_flags", {clk_en, refreshBar, busy, timeout_err}, 0);

    // Two-cycle glitch on down must not reach the FSM.
    btn_down_n = 1'b0; cycles(2); btn_down_n = 1'b1;
    cycles(12);
    check("glitch_no_pulse", pulses, 0);

    // Stable down press: one strobe to 200, ack 10 cycles later.
    btn_down_n = 1'b0;
    wait_pulse(40, ok);
    check("down_pulse_seen", ok, 1);
    check("down_coordY", coordY, 200);
    check("down_refreshBar", refreshBar, 1);
    btn_down_n = 1'b1;
    cycles(1);
    check("issue_one_cycle", clk_en, 0);
    cycles(9);
    check("busy_wait_ack", busy, 1);
    y_Atual = 9'd200;
    cycles(1);
    check("busy_after_ack", busy, 0);
    cycles(20);
    check("down_single_pulse", pulses, 1);

    // No ack: target 205 while renderer sits at 7; timeout after 64 wait cycles.
    btn_down_n = 1'b0;
    wait_pulse(40, ok);
    check("to_pulse_seen", ok, 1);
    check("to_coordY", coordY, 205);
    btn_down_n = 1'b1;
    y_Atual = 9'd7;
    cycles(64);
    check("to_not_yet", timeout_err, 0);
    check("to_busy_before", busy, 1);
    cycles(1);
    check("to_flag_set", timeout_err, 1);
    check("to_busy_clear", busy, 0);
    cycles(5);
    check("to_flag_sticky", timeout_err, 1);
    clr_err = 1'b1; cycles(1); clr_err = 1'b0;
    check("to_flag_cleared", timeout_err, 0);

    // Hold up from resynchronized pos=7: 2, then clamp at 0, then nothing.
    base = pulses;
    btn_up_n = 1'b0;
    wait_pulse(40, ok);
    check("up1_pulse_seen", ok, 1);
    check("up1_coordY", coordY, 2);
    cycles(3); y_Atual = 9'd2;
    wait_pulse(60, ok);
    check("up2_pulse_seen", ok, 1);
    check("up2_coordY", coordY, 0);
    cycles(3); y_Atual = 9'd0;
    cycles(60);
    check("up_limit_pulses", pulses, base + 2);
    check("up_limit_busy", busy, 0);
    btn_up_n = 1'b1;
    cycles(10);

    // Force pos=385 via a timeout, then down clamps to 389 once.
    btn_down_n = 1'b0;
    wait_pulse(40, ok);
    check("pre385_coordY", coordY, 5);
    btn_down_n = 1'b1;
    y_Atual = 9'd385;
    cycles(70);
    check("pre385_timeout", timeout_err, 1);
    clr_err = 1'b1; cycles(1); clr_err = 1'b0;
    base = pulses;
    btn_down_n = 1'b0;
    wait_pulse(40, ok);
    check("max_pulse_seen", ok, 1);
    check("max_coordY", coordY, 389);
    cycles(3); y_Atual = 9'd389;
    cycles(60);
    check("max_single_pulse", pulses, base + 1);
    btn_down_n = 1'b1;
    cycles(10);

    // Enable low blocks requests.
    base = pulses;
    enable = 1'b0; btn_up_n = 1'b0;
    cycles(30);
    check("disabled_no_pulse", pulses, base);
    btn_up_n = 1'b1;
    cycles(10);
    enable = 1'b1;

    // Both buttons pressed: no request.
    btn_up_n = 1'b0; btn_down_n = 1'b0;
    cycles(30);
    check("both_no_pulse", pulses, base);
    btn_up_n = 1'b1; btn_down_n = 1'b1;
    cycles(10);

    // Asynchronous reset while waiting for an ack.
    btn_up_n = 1'b0;
    wait_pulse(40, ok);
    check("rst_pulse_seen", ok, 1);
    check("rst_pre_coordY", coordY, 384);
    btn_up_n = 1'b1;
    cycles(5);
    check("rst_pre_busy", busy, 1);
    #1 i_rst = 1'b0;
    #1;
    check("rst_async_busy", busy, 0);
    check("rst_async_coordY", coordY, 195);
    check("rst_async_strobe", {clk_en, refreshBar, timeout_err}, 0);
    cycles(2);
    i_rst = 1'b1;
    cycles(20);
    check("post_rst_coordY", coordY, 195);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
